// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel coordinates, sync pins and frame/second strobes
// that travel together from the timing source to the sprite/background logic.
interface vga_timing_gen_if;
    logic [9:0] Hcount;
    logic [9:0] Vcount;
    logic       Hsync;
    logic       Vsync;
    logic       active;
    logic       frame;
    logic       sec;

    modport master (
        output Hcount, Vcount, Hsync, Vsync, active, frame, sec
    );

    modport slave (
        input  Hcount, Vcount, Hsync, Vsync, active, frame, sec
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480 raster timing source: pixel/line counters, active-low syncs, active
// flag, per-frame and once-per-second strobes, all registered on the same edge.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE      = 640,
    parameter int unsigned H_SYNC_START   = 655,
    parameter int unsigned H_SYNC_END     = 750,
    parameter int unsigned H_TOTAL        = 800,
    parameter int unsigned V_VISIBLE      = 480,
    parameter int unsigned V_SYNC_START   = 489,
    parameter int unsigned V_SYNC_END     = 490,
    parameter int unsigned V_TOTAL        = 525,
    parameter int unsigned FRAMES_PER_SEC = 60
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  vga
);

    localparam int unsigned CW = 10;
    localparam int unsigned FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          active_q, active_d;
    logic          frame_q, frame_d;
    logic          sec_q, sec_d;

    // Every output is decoded from the next counter values so that all of
    // them are registered together and describe the same pixel.
    always_comb begin
        h_d      = h_q + CW'(1);
        v_d      = v_q;
        fcnt_d   = fcnt_q;
        hsync_d  = 1'b1;
        vsync_d  = 1'b1;
        active_d = 1'b0;
        frame_d  = 1'b0;
        sec_d    = 1'b0;

        if (h_q == CW'(H_TOTAL - 1)) begin
            h_d = '0;
            if (v_q == CW'(V_TOTAL - 1)) begin
                v_d = '0;
            end else begin
                v_d = v_q + CW'(1);
            end
        end

        hsync_d  = !((h_d >= CW'(H_SYNC_START)) && (h_d <= CW'(H_SYNC_END)));
        vsync_d  = !((v_d >= CW'(V_SYNC_START)) && (v_d <= CW'(V_SYNC_END)));
        active_d = (h_d < CW'(H_VISIBLE)) && (v_d < CW'(V_VISIBLE));
        frame_d  = (h_d == '0) && (v_d == CW'(V_VISIBLE));
        sec_d    = frame_d && (fcnt_q == FW'(FRAMES_PER_SEC - 1));

        // Frame counter advances only on a frame pulse and wraps with sec.
        if (frame_d) begin
            fcnt_d = sec_d ? '0 : fcnt_q + FW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q      <= '0;
            v_q      <= '0;
            fcnt_q   <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            active_q <= 1'b1;
            frame_q  <= 1'b0;
            sec_q    <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            fcnt_q   <= fcnt_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            frame_q  <= frame_d;
            sec_q    <= sec_d;
        end
    end

    assign vga.Hcount = h_q;
    assign vga.Vcount = v_q;
    assign vga.Hsync  = hsync_q;
    assign vga.Vsync  = vsync_q;
    assign vga.active = active_q;
    assign vga.frame  = frame_q;
    assign vga.sec    = sec_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster (16x10, 3 frames/sec)
// with per-cycle checks against an arithmetic model of elapsed cycles.
module tb_vga_timing_gen;

    localparam int HV  = 8;
    localparam int HSS = 10;
    localparam int HSE = 12;
    localparam int HT  = 16;
    localparam int VV  = 6;
    localparam int VSS = 7;
    localparam int VSE = 8;
    localparam int VT  = 10;
    localparam int FPS = 3;

    logic clk;
    logic reset;
    int   t;
    int   passed;
    int   total;

    vga_timing_gen_if bus ();

    vga_timing_gen #(
        .H_VISIBLE      (HV),
        .H_SYNC_START   (HSS),
        .H_SYNC_END     (HSE),
        .H_TOTAL        (HT),
        .V_VISIBLE      (VV),
        .V_SYNC_START   (VSS),
        .V_SYNC_END     (VSE),
        .V_TOTAL        (VT),
        .FRAMES_PER_SEC (FPS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vga   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s t=%0d: observed %0d expected %0d", tag, t, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_hcount", 32'(bus.Hcount), 0);
        chk("rst_vcount", 32'(bus.Vcount), 0);
        chk("rst_hsync",  32'(bus.Hsync),  1);
        chk("rst_vsync",  32'(bus.Vsync),  1);
        chk("rst_active", 32'(bus.active), 1);
        chk("rst_frame",  32'(bus.frame),  0);
        chk("rst_sec",    32'(bus.sec),    0);
    endtask

    // Expected outputs as a function of cycles since reset release.
    task automatic check_all();
        int h, v, k;
        logic fr, sc;
        h  = t % HT;
        v  = (t / HT) % VT;
        fr = (h == 0) && (v == VV);
        k  = fr ? (t - VV * HT) / (HT * VT) + 1 : 0;
        sc = fr && (k % FPS == 0);
        chk("hcount", 32'(bus.Hcount), 32'(h));
        chk("vcount", 32'(bus.Vcount), 32'(v));
        chk("hsync",  32'(bus.Hsync),  32'(!(h >= HSS && h <= HSE)));
        chk("vsync",  32'(bus.Vsync),  32'(!(v >= VSS && v <= VSE)));
        chk("active", 32'(bus.active), 32'(h < HV && v < VV));
        chk("frame",  32'(bus.frame),  32'(fr));
        chk("sec",    32'(bus.sec),    32'(sc));
    endtask

    task automatic run(input int n);
        repeat (n) begin
            tick();
            t++;
            check_all();
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            tick();
            chk_reset();
        end
        reset = 1'b0;
        t = 0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        t      = 0;
        reset  = 1'b1;

        do_reset(5);

        run(1);
        chk("hcount_after_release", 32'(bus.Hcount), 1);
        run(14);
        chk("line_end_h", 32'(bus.Hcount), 15);
        chk("line_end_v", 32'(bus.Vcount), 0);
        run(1);
        chk("line_wrap_h", 32'(bus.Hcount), 0);
        chk("line_wrap_v", 32'(bus.Vcount), 1);
        run(80);
        chk("first_frame", 32'(bus.frame), 1);
        chk("first_frame_v", 32'(bus.Vcount), 6);
        chk("first_frame_active", 32'(bus.active), 0);
        run(63);
        chk("frame_end_h", 32'(bus.Hcount), 15);
        chk("frame_end_v", 32'(bus.Vcount), 9);
        run(1);
        chk("frame_wrap_h", 32'(bus.Hcount), 0);
        chk("frame_wrap_v", 32'(bus.Vcount), 0);
        run(256);
        chk("first_sec", 32'(bus.sec), 1);
        chk("first_sec_frame", 32'(bus.frame), 1);
        run(1);
        chk("sec_width", 32'(bus.sec), 0);
        run(479);
        chk("second_sec", 32'(bus.sec), 1);
        run(117);

        // Mid-frame reset at pixel (5,3).
        chk("mid_pos_h", 32'(bus.Hcount), 5);
        chk("mid_pos_v", 32'(bus.Vcount), 3);
        do_reset(1);
        run(40);

        // Reset while sec/frame are high.
        run(376);
        chk("pre_reset_sec", 32'(bus.sec), 1);
        do_reset(1);
        run(20);

        // Reset sampled in the cycle before a frame pulse suppresses it.
        run(75);
        chk("pre_frame_h", 32'(bus.Hcount), 15);
        chk("pre_frame_v", 32'(bus.Vcount), 5);
        do_reset(1);
        run(96);
        chk("frame_after_reset", 32'(bus.frame), 1);

        // Reset after one frame: fcnt must restart so sec is 3 frames away.
        run(159);
        do_reset(1);
        run(420);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
